// File: rtl/wb_regfile.sv
// Writeback stage and 32 x XLEN integer register file with retire counter.
// Optional WB_READ_BYPASS_EN: same-cycle write-first reads of rd_store.
module wb_regfile #(
    parameter int XLEN  = 64,
    parameter int NREG  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             RegWrite_store,
    input  logic             MemtoReg_store,
    input  logic [XLEN-1:0]  ReadData_store,
    input  logic [XLEN-1:0]  ALU_result_store,
    input  logic [4:0]       rd_store,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    output logic [XLEN-1:0]  ReadData1,
    output logic [XLEN-1:0]  ReadData2,
    output logic [XLEN-1:0]  wb_data,
    output logic             wb_valid,
    output logic [CNT_W-1:0] retire_count
);

    logic [XLEN-1:0]  regs_q [NREG];
    logic [XLEN-1:0]  regs_d [NREG];
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // The mux alone keeps stale load data out of the array when MemtoReg_store=0.
    always_comb begin
        wb_data  = MemtoReg_store ? ReadData_store : ALU_result_store;
        wb_valid = RegWrite_store && (rd_store != 5'd0);
    end

    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (wb_valid && (int'(rd_store) < NREG)) begin
            regs_d[rd_store] = wb_data;
        end
        regs_d[0] = '0;
        cnt_d = cnt_q + CNT_W'(wb_valid);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            cnt_q <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        ReadData1 = '0;
        ReadData2 = '0;
        if ((rs1 != 5'd0) && (int'(rs1) < NREG)) begin
            ReadData1 = regs_q[rs1];
        end
        if ((rs2 != 5'd0) && (int'(rs2) < NREG)) begin
            ReadData2 = regs_q[rs2];
        end
`ifdef WB_READ_BYPASS_EN
        // Write-first: the value committing at the next edge is visible now.
        if (wb_valid && (rs1 == rd_store)) begin
            ReadData1 = wb_data;
        end
        if (wb_valid && (rs2 == rd_store)) begin
            ReadData2 = wb_data;
        end
`endif
    end

    assign retire_count = cnt_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: array/counter model plus directed literal checks.
// A CNT_W=4 instance shares all stimulus to exercise counter wrap.
module tb_wb_regfile;

    logic        clk;
    logic        reset_n;
    logic        RegWrite_store;
    logic        MemtoReg_store;
    logic [63:0] ReadData_store;
    logic [63:0] ALU_result_store;
    logic [4:0]  rd_store;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [63:0] ReadData1;
    logic [63:0] ReadData2;
    logic [63:0] wb_data;
    logic        wb_valid;
    logic [31:0] retire_count;
    logic [63:0] n_rd1;
    logic [63:0] n_rd2;
    logic [63:0] n_wb_data;
    logic        n_wb_valid;
    logic [3:0]  n_retire_count;

    int          n_tests;
    int          n_fail;
    logic        chk_en;

    logic [63:0] mdl [32];
    logic [31:0] mdl_cnt;

    wb_regfile #(.XLEN(64), .NREG(32), .CNT_W(32)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .RegWrite_store   (RegWrite_store),
        .MemtoReg_store   (MemtoReg_store),
        .ReadData_store   (ReadData_store),
        .ALU_result_store (ALU_result_store),
        .rd_store         (rd_store),
        .rs1              (rs1),
        .rs2              (rs2),
        .ReadData1        (ReadData1),
        .ReadData2        (ReadData2),
        .wb_data          (wb_data),
        .wb_valid         (wb_valid),
        .retire_count     (retire_count)
    );

    wb_regfile #(.XLEN(64), .NREG(32), .CNT_W(4)) dut_narrow (
        .clk              (clk),
        .reset_n          (reset_n),
        .RegWrite_store   (RegWrite_store),
        .MemtoReg_store   (MemtoReg_store),
        .ReadData_store   (ReadData_store),
        .ALU_result_store (ALU_result_store),
        .rd_store         (rd_store),
        .rs1              (rs1),
        .rs2              (rs2),
        .ReadData1        (n_rd1),
        .ReadData2        (n_rd2),
        .wb_data          (n_wb_data),
        .wb_valid         (n_wb_valid),
        .retire_count     (n_retire_count)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] exp_wb();
        return MemtoReg_store ? ReadData_store : ALU_result_store;
    endfunction

    function automatic logic [63:0] exp_read(input logic [4:0] rs);
        if (rs == 5'd0) return 64'd0;
`ifdef WB_READ_BYPASS_EN
        if (RegWrite_store && (rd_store != 5'd0) && (rs == rd_store)) return exp_wb();
`endif
        return mdl[rs];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 32; i++) mdl[i] = 64'd0;
        mdl_cnt = 32'd0;
    endtask

    // model commit: one write per edge with reset released
    always @(posedge clk) begin
        if (reset_n === 1'b1 && RegWrite_store && rd_store != 5'd0) begin
            mdl[rd_store] = exp_wb();
            mdl_cnt = mdl_cnt + 32'd1;
        end
    end

    // compare process: mid-cycle, inputs settled since the negedge
    always @(negedge clk) begin
        #2;
        if (chk_en) begin
            check("wb_data", wb_data, exp_wb());
            check("wb_valid", {63'd0, wb_valid}, {63'd0, RegWrite_store && rd_store != 5'd0});
            check("ReadData1", ReadData1, exp_read(rs1));
            check("ReadData2", ReadData2, exp_read(rs2));
            check("retire_count", {32'd0, retire_count}, {32'd0, mdl_cnt});
            check("narrow_retire_count", {60'd0, n_retire_count}, {60'd0, mdl_cnt[3:0]});
            check("narrow_ReadData1", n_rd1, exp_read(rs1));
        end
    end

    // driver tasks
    task automatic drive(input logic rw, input logic mtr, input logic [63:0] rdata,
                         input logic [63:0] alu, input logic [4:0] rd,
                         input logic [4:0] r1, input logic [4:0] r2);
        @(negedge clk);
        RegWrite_store   = rw;
        MemtoReg_store   = mtr;
        ReadData_store   = rdata;
        ALU_result_store = alu;
        rd_store         = rd;
        rs1              = r1;
        rs2              = r2;
    endtask

    // Reset is released just after an edge, so that edge still sees reset active.
    task automatic reset_pulse(input int edges);
        reset_n = 1'b0;
        clear_model();
        repeat (edges) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    initial begin
        n_tests = 0;
        n_fail = 0;
        chk_en = 1'b0;
        RegWrite_store = 1'b0;
        MemtoReg_store = 1'b0;
        ReadData_store = 64'd0;
        ALU_result_store = 64'd0;
        rd_store = 5'd0;
        rs1 = 5'd0;
        rs2 = 5'd0;
        reset_pulse(2);
        chk_en = 1'b1;
        check("reset_retire_count", {32'd0, retire_count}, 64'd0);

        // random writes, then reset and sweep both read ports
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b0, 'x, {$urandom, $urandom}, 5'($urandom_range(1, 31)),
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        end
        drive(1'b0, 1'b0, 64'd0, 64'd0, 5'd0, 5'd0, 5'd0);
        #3 reset_pulse(2);
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 1'b0, 64'd0, 64'd0, 5'd0, 5'(i), 5'(31 - i));
            #3;
            check("sweep_rs1", ReadData1, 64'd0);
            check("sweep_rs2", ReadData2, 64'd0);
        end
        check("post_reset_count", {32'd0, retire_count}, 64'd0);

        // ALU writeback with X on the load path
        drive(1'b1, 1'b0, 'x, 64'hDEAD_BEEF_0000_0005, 5'd7, 5'd0, 5'd0);
        drive(1'b0, 1'b0, 64'd0, 64'd0, 5'd0, 5'd7, 5'd0);
        #3;
        check("alu_wb_x7", ReadData1, 64'hDEAD_BEEF_0000_0005);
        check("alu_wb_count", {32'd0, retire_count}, 64'd1);

        // load writeback, then dropped x0 write
        drive(1'b1, 1'b1, 64'h1234, 64'h9999, 5'd3, 5'd0, 5'd0);
        drive(1'b1, 1'b0, 'x, 64'hFFFF, 5'd0, 5'd3, 5'd0);
        #3;
        check("x0_wb_valid", {63'd0, wb_valid}, 64'd0);
        check("load_wb_x3", ReadData1, 64'h1234);
        check("x0_read_pre", ReadData2, 64'd0);
        drive(1'b0, 1'b0, 64'd0, 64'd0, 5'd0, 5'd0, 5'd3);
        #3;
        check("x0_read", ReadData1, 64'd0);
        check("x0_count", {32'd0, retire_count}, 64'd2);

        // same-cycle read of rd_store on both ports
        drive(1'b1, 1'b0, 'x, 64'h11, 5'd5, 5'd0, 5'd0);
        drive(1'b1, 1'b0, 'x, 64'hA5, 5'd5, 5'd5, 5'd5);
        #3;
`ifdef WB_READ_BYPASS_EN
        check("bypass_rs1", ReadData1, 64'hA5);
        check("bypass_rs2", ReadData2, 64'hA5);
`else
        check("readold_rs1", ReadData1, 64'h11);
        check("readold_rs2", ReadData2, 64'h11);
`endif
        drive(1'b0, 1'b0, 64'd0, 64'd0, 5'd0, 5'd5, 5'd5);
        #3;
        check("after_edge_rs1", ReadData1, 64'hA5);
        check("after_edge_rs2", ReadData2, 64'hA5);

        // RegWrite=0 leaves state alone
        drive(1'b0, 1'b0, 'x, 64'h77, 5'd9, 5'd9, 5'd9);
        drive(1'b0, 1'b0, 64'd0, 64'd0, 5'd0, 5'd9, 5'd5);
        #3;
        check("nowrite_x9", ReadData1, 64'd0);
        check("nowrite_count", {32'd0, retire_count}, 64'd4);

        // 17 back-to-back writes, then async reset mid-stream
        drive(1'b0, 1'b0, 64'd0, 64'd0, 5'd0, 5'd0, 5'd0);
        #3 reset_pulse(1);
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 1'b0, 'x, 64'(100 + i), 5'((i % 31) + 1), 5'd1, 5'd2);
        end
        drive(1'b1, 1'b0, 'x, 64'hBEEF, 5'd21, 5'd1, 5'd17);
        #3;
        check("wrap_count_narrow", {60'd0, n_retire_count}, 64'd1);
        check("wrap_count_wide", {32'd0, retire_count}, 64'd17);
        check("pre_reset_x1", ReadData1, 64'd100);
        reset_n = 1'b0;
        clear_model();
        #1;
        check("async_clear_x1", ReadData1, 64'd0);
        check("async_clear_x17", ReadData2, 64'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        drive(1'b0, 1'b0, 64'd0, 64'd0, 5'd0, 5'd21, 5'd21);
        #3;
        check("release_edge_x21", ReadData1, 64'd0);
        check("release_edge_count", {32'd0, retire_count}, 64'd0);

        // first edge with reset high commits
        drive(1'b1, 1'b1, 64'h55, 'x, 5'd21, 5'd0, 5'd0);
        drive(1'b0, 1'b0, 64'd0, 64'd0, 5'd0, 5'd21, 5'd0);
        #3;
        check("first_commit_x21", ReadData1, 64'h55);
        check("first_commit_count", {32'd0, retire_count}, 64'd1);

        @(negedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
